pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central pipeline stall/flush controller. It drives the `stall_state` vector and the branch flush flag that every inter-stage pipeline register samples. It merges stall requests from IF, ID and MEM with branch resolution from EX. It defers redirects that arrive while EX is frozen, and it discards the one stale fetch that is in flight when a redirect is issued.

Parameters:
- ADDR_W, 32, width of the PC and branch target
- STALL_W, 6, width of `stall_state` (`StallBus`)

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-low reset (rst==0 resets)
- if_stall_req  in  1  fetch not ready (icache miss or bus wait)
- if_busy  in  1  a fetch request is outstanding
- if_rsp_valid  in  1  fetch response returns this cycle
- id_stall_req  in  1  load-use hazard detected in ID
- mem_stall_req  in  1  MEM stage cannot complete this cycle
- ex_b_flag  in  1  EX resolved a taken branch/jump (redirect needed)
- ex_b_target  in  ADDR_W  redirect address from EX
- stall_state  out  STALL_W  bit k=1 holds stage k: [0] IF/PC, [1] ID, [2] EX, [3] MEM, [4] WB, [5] reserved=0
- b_flag_o  out  1  flush IF/ID and ID/EX this cycle
- redirect_en  out  1  PC loads redirect_addr this cycle
- redirect_addr  out  ADDR_W  new PC
- if_kill  out  1  drop the next returning fetch response

Behaviour:
- All outputs are combinational from inputs and registered state (Mealy). Zero-cycle response to requests.
- Registered state: `state`, `pend_target`[ADDR_W].
- Reset (rst==0, async): state=S_RUN, pend_target=0. Outputs are then stall_state=0, b_flag_o=0, redirect_en=0, redirect_addr=0, if_kill=0 while inputs are idle.
- Stall vector, monotone; the highest requester wins:
  - mem_stall_req -> bits[3:0]=1111. MEM/WB receives a bubble.
  - else id_stall_req -> bits[1:0]=11. EX receives a bubble.
  - else if_stall_req -> bit[0]=1.
  - bit[4] and bit[5] are always 0.
- Flush override: in any cycle with b_flag_o=1, id_stall_req and if_stall_req are ignored because they concern the wrong path. mem_stall_req never co-occurs with b_flag_o by construction.
- State S_RUN:
  - ex_b_flag & mem_stall_req: latch pend_target=ex_b_target, go to S_BR_HOLD. b_flag_o=0 because EX is frozen.
  - ex_b_flag & !mem_stall_req: b_flag_o=1, redirect_en=1, redirect_addr=ex_b_target. Next state is S_FETCH_KILL if (if_busy & !if_rsp_valid), else S_RUN.
- State S_BR_HOLD:
  - ex_b_flag is ignored (same EX instruction is re-asserting).
  - While mem_stall_req: hold.
  - On first cycle with mem_stall_req=0: b_flag_o=1, redirect_en=1, redirect_addr=pend_target. Next state follows the same if_busy rule as S_RUN.
- State S_FETCH_KILL:
  - if_kill=1 and stall_state[0] is forced to 1, so no new fetch issues.
  - On if_rsp_valid: the response is discarded and state goes to S_RUN. if_kill deasserts the next cycle.
  - A new ex_b_flag here takes priority: issue a fresh redirect and stay in S_FETCH_KILL.
- redirect_addr is 0 whenever redirect_en=0.
- Async reset mid-S_BR_HOLD drops the pending redirect. The core restarts from the reset PC.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined: adds outputs `perf_stall_cyc`[32] and `perf_flush_cnt`[32].
  - perf_stall_cyc counts cycles with stall_state[0]=1.
  - perf_flush_cnt counts cycles with b_flag_o=1.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: no counters and no such ports; behaviour is otherwise identical.

Decomposition:
- Shared defines file holds:
  - `StallBus`, stall bit indices (STALL_IF..STALL_WB)
  - state encodings S_RUN/S_BR_HOLD/S_FETCH_KILL
  - `ZeroWord`, `True`/`False`
- Counters go in an optional sub-module `pipe_perf_cnt`, instantiated only under PIPE_CTRL_PERF_EN. The rest stays flat.

Test Plan:
- Reset pulse (rst=0 mid-run) with mem_stall_req=1 -> stall_state=000000 once requests drop; state=S_RUN; pend_target=0.
- id_stall_req=1 and mem_stall_req=1 together -> stall_state=001111; with only id_stall_req -> 000011; only if_stall_req -> 000001.
- ex_b_flag=1, target 0x0000_1040, if_busy=0 -> same cycle b_flag_o=1, redirect_en=1, redirect_addr=0x1040; next cycle all flush outputs 0.
- ex_b_flag=1 (target 0x2000) while mem_stall_req=1 for 3 cycles -> b_flag_o=0 for those 3 cycles; cycle 4 (mem_stall_req=0) b_flag_o=1, redirect_addr=0x2000.
- Redirect with if_busy=1 and response 2 cycles later -> if_kill=1 and stall_state[0]=1 until the if_rsp_valid cycle; then S_RUN.
- With PIPE_CTRL_PERF_EN: 5 IF-stall cycles plus 2 redirects -> perf_stall_cyc=5, perf_flush_cnt=2.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stall bus
// layout, controller state encodings and common constants.
package pipe_ctrl_pkg;

    localparam int STALL_BUS_W = 6;

    typedef logic [STALL_BUS_W-1:0] StallBus;

    // Bit k of the stall bus holds stage k; bit 5 is reserved and stays 0.
    localparam int STALL_IF  = 0;
    localparam int STALL_ID  = 1;
    localparam int STALL_EX  = 2;
    localparam int STALL_MEM = 3;
    localparam int STALL_WB  = 4;

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_BR_HOLD    = 2'd1,
        S_FETCH_KILL = 2'd2
    } ctrl_state_t;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;
    localparam logic        True     = 1'b1;
    localparam logic        False    = 1'b0;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating performance counters for the pipeline controller: cycles with
// the fetch stage held, and cycles in which a branch flush was issued.
// Only instantiated when PIPE_CTRL_PERF_EN is defined.
module pipe_perf_cnt
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        flush,
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_flush_cnt
);

    // Count events, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cyc <= ZeroWord;
            perf_flush_cnt <= ZeroWord;
        end else begin
            if (stall_if && (perf_stall_cyc != 32'hFFFF_FFFF))
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            if (flush && (perf_flush_cnt != 32'hFFFF_FFFF))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller. Merges IF/ID/MEM stall requests with EX
// branch resolution, defers redirects while EX is frozen by MEM, and kills
// the one stale fetch in flight when a redirect is issued.
// Optional build macro PIPE_CTRL_PERF_EN adds perf_stall_cyc/perf_flush_cnt.
//
// state        | meaning
// -------------+--------------------------------------------------------
// S_RUN        | normal flow, branches redirect in the cycle they resolve
// S_BR_HOLD    | taken branch seen while MEM stalled, target held pending
// S_FETCH_KILL | redirect issued with a fetch outstanding, drop its reply
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int STALL_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_stall_req,
    input  logic               if_busy,
    input  logic               if_rsp_valid,
    input  logic               id_stall_req,
    input  logic               mem_stall_req,
    input  logic               ex_b_flag,
    input  logic [ADDR_W-1:0]  ex_b_target,
    output logic [STALL_W-1:0] stall_state,
    output logic               b_flag_o,
    output logic               redirect_en,
    output logic [ADDR_W-1:0]  redirect_addr,
    output logic               if_kill
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]        perf_stall_cyc,
    output logic [31:0]        perf_flush_cnt
`endif
);

    ctrl_state_t       state, state_nxt;
    logic [ADDR_W-1:0] pend_target, pend_nxt;
    logic              fetch_open;

    // A redirect leaves a stale fetch behind only if the request is still
    // outstanding and its reply is not arriving in this very cycle.
    assign fetch_open = if_busy & ~if_rsp_valid;

    // State and pending-target registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_RUN;
            pend_target <= '0;
        end else begin
            state       <= state_nxt;
            pend_target <= pend_nxt;
        end
    end

    // Next state plus Mealy flush/redirect outputs.
    always_comb begin
        state_nxt     = state;
        pend_nxt      = pend_target;
        b_flag_o      = False;
        redirect_en   = False;
        redirect_addr = '0;
        if_kill       = False;
        case (state)
            S_RUN: begin
                if (ex_b_flag) begin
                    if (mem_stall_req) begin
                        pend_nxt  = ex_b_target;
                        state_nxt = S_BR_HOLD;
                    end else begin
                        b_flag_o      = True;
                        redirect_en   = True;
                        redirect_addr = ex_b_target;
                        state_nxt     = fetch_open ? S_FETCH_KILL : S_RUN;
                    end
                end
            end
            S_BR_HOLD: begin
                // EX keeps re-asserting the same branch here, so ex_b_flag
                // carries no new information until the redirect is issued.
                if (!mem_stall_req) begin
                    b_flag_o      = True;
                    redirect_en   = True;
                    redirect_addr = pend_target;
                    state_nxt     = fetch_open ? S_FETCH_KILL : S_RUN;
                end
            end
            S_FETCH_KILL: begin
                if_kill = True;
                if (ex_b_flag && !mem_stall_req) begin
                    // Fresh redirect; the kill window stays open for it.
                    b_flag_o      = True;
                    redirect_en   = True;
                    redirect_addr = ex_b_target;
                end else if (ex_b_flag) begin
                    pend_nxt  = ex_b_target;
                    state_nxt = S_BR_HOLD;
                end else if (if_rsp_valid) begin
                    state_nxt = S_RUN;
                end
            end
            default: begin
                state_nxt = S_RUN;
            end
        endcase
    end

    // Monotone stall vector; wrong-path IF/ID requests are ignored on flush.
    always_comb begin
        stall_state = '0;
        if (mem_stall_req) begin
            stall_state[STALL_MEM] = True;
            stall_state[STALL_EX]  = True;
            stall_state[STALL_ID]  = True;
            stall_state[STALL_IF]  = True;
        end else if (id_stall_req && !b_flag_o) begin
            stall_state[STALL_ID]  = True;
            stall_state[STALL_IF]  = True;
        end else if (if_stall_req && !b_flag_o) begin
            stall_state[STALL_IF]  = True;
        end
        if (state == S_FETCH_KILL)
            stall_state[STALL_IF] = True;
        stall_state[STALL_WB] = False;
    end

`ifdef PIPE_CTRL_PERF_EN
    pipe_perf_cnt u_perf_cnt (
        .clk            (clk),
        .rst            (rst),
        .stall_if       (stall_state[STALL_IF]),
        .flush          (b_flag_o),
        .perf_stall_cyc (perf_stall_cyc),
        .perf_flush_cnt (perf_flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios followed by random traffic,
// all compared against a behavioural model tracking "redirect pending" and
// "stale fetch outstanding" as plain flags.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_stall_req = 1'b0, if_busy = 1'b0, if_rsp_valid = 1'b0;
    logic        id_stall_req = 1'b0, mem_stall_req = 1'b0, ex_b_flag = 1'b0;
    logic [31:0] ex_b_target = '0;
    logic [5:0]  stall_state;
    logic        b_flag_o, redirect_en, if_kill;
    logic [31:0] redirect_addr;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cyc, perf_flush_cnt;
`endif

    pipe_ctrl #(.ADDR_W(32), .STALL_W(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_stall_req  (if_stall_req),
        .if_busy       (if_busy),
        .if_rsp_valid  (if_rsp_valid),
        .id_stall_req  (id_stall_req),
        .mem_stall_req (mem_stall_req),
        .ex_b_flag     (ex_b_flag),
        .ex_b_target   (ex_b_target),
        .stall_state   (stall_state),
        .b_flag_o      (b_flag_o),
        .redirect_en   (redirect_en),
        .redirect_addr (redirect_addr),
        .if_kill       (if_kill)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cyc(perf_stall_cyc),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: a deferred redirect and an outstanding stale fetch.
    logic        m_pend_valid, m_kill;
    logic [31:0] m_pend_addr;
    logic        n_pend_valid, n_kill;
    logic [31:0] n_pend_addr;
    logic [5:0]  m_stall;
    logic        m_flush;
    logic [31:0] m_addr;
    longint      m_stall_cnt, m_flush_cnt;

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic ifs, input logic busy, input logic rsp, input logic ids,
                         input logic mems, input logic exb, input logic [31:0] tgt);
        if_stall_req  = ifs;
        if_busy       = busy;
        if_rsp_valid  = rsp;
        id_stall_req  = ids;
        mem_stall_req = mems;
        ex_b_flag     = exb;
        ex_b_target   = tgt;
    endtask

    task automatic model_reset();
        m_pend_valid = 1'b0;
        m_pend_addr  = '0;
        m_kill       = 1'b0;
        m_stall_cnt  = 0;
        m_flush_cnt  = 0;
    endtask

    // Evaluate the model against current inputs and compare all outputs.
    task automatic eval_check();
        m_flush      = 1'b0;
        m_addr       = '0;
        n_kill       = m_kill;
        n_pend_valid = m_pend_valid;
        n_pend_addr  = m_pend_addr;
        if (m_kill) begin
            if (ex_b_flag && !mem_stall_req) begin
                m_flush = 1'b1; m_addr = ex_b_target;
            end else if (ex_b_flag) begin
                n_pend_valid = 1'b1; n_pend_addr = ex_b_target; n_kill = 1'b0;
            end else if (if_rsp_valid) begin
                n_kill = 1'b0;
            end
        end else if (m_pend_valid) begin
            if (!mem_stall_req) begin
                m_flush = 1'b1; m_addr = m_pend_addr; n_pend_valid = 1'b0;
                n_kill = if_busy && !if_rsp_valid;
            end
        end else if (ex_b_flag) begin
            if (mem_stall_req) begin
                n_pend_valid = 1'b1; n_pend_addr = ex_b_target;
            end else begin
                m_flush = 1'b1; m_addr = ex_b_target;
                n_kill = if_busy && !if_rsp_valid;
            end
        end
        if (mem_stall_req)                m_stall = 6'b001111;
        else if (!m_flush && id_stall_req) m_stall = 6'b000011;
        else if (!m_flush && if_stall_req) m_stall = 6'b000001;
        else                               m_stall = 6'b000000;
        if (m_kill) m_stall[0] = 1'b1;

        chk_val("stall_state",   64'(stall_state),   64'(m_stall));
        chk_val("b_flag_o",      64'(b_flag_o),      64'(m_flush));
        chk_val("redirect_en",   64'(redirect_en),   64'(m_flush));
        chk_val("redirect_addr", 64'(redirect_addr), 64'(m_addr));
        chk_val("if_kill",       64'(if_kill),       64'(m_kill));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (m_stall[0] && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
        if (m_flush && m_flush_cnt < 64'hFFFF_FFFF)    m_flush_cnt++;
        m_kill       = n_kill;
        m_pend_valid = n_pend_valid;
        m_pend_addr  = n_pend_addr;
    endtask

    task automatic step(input logic ifs, input logic busy, input logic rsp, input logic ids,
                        input logic mems, input logic exb, input logic [31:0] tgt);
        drive(ifs, busy, rsp, ids, mems, exb, tgt);
        #3;
        eval_check();
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b1;
    endtask

    initial begin
        logic ifs, busy, rsp, ids, mems, exb;

        model_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Idle after reset.
        step(0, 0, 0, 0, 0, 0, 32'h0);
        chk_val("rst_stall", 64'(stall_state), 64'h0);
        chk_val("rst_addr",  64'(redirect_addr), 64'h0);
        tick();

        // Stall priority.
        step(0, 0, 0, 1, 1, 0, 32'h0);
        chk_val("id_mem_stall", 64'(stall_state), 64'b001111);
        tick();
        step(0, 0, 0, 1, 0, 0, 32'h0);
        chk_val("id_stall", 64'(stall_state), 64'b000011);
        tick();
        step(1, 0, 0, 0, 0, 0, 32'h0);
        chk_val("if_stall", 64'(stall_state), 64'b000001);
        tick();

        // Immediate redirect, no fetch outstanding.
        step(1, 0, 0, 1, 0, 1, 32'h0000_1040);
        chk_val("br_flag", 64'(b_flag_o), 64'h1);
        chk_val("br_addr", 64'(redirect_addr), 64'h1040);
        chk_val("br_stall_ignored", 64'(stall_state), 64'h0);
        tick();
        step(0, 0, 0, 0, 0, 0, 32'h0);
        chk_val("br_after", 64'(b_flag_o), 64'h0);
        tick();

        // Branch deferred by three MEM-stall cycles.
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1, 1, 32'h0000_2000);
            chk_val("hold_flag", 64'(b_flag_o), 64'h0);
            tick();
        end
        step(0, 0, 0, 0, 0, 1, 32'h0000_2000);
        chk_val("hold_release", 64'(b_flag_o), 64'h1);
        chk_val("hold_addr", 64'(redirect_addr), 64'h2000);
        tick();
        step(0, 0, 0, 0, 0, 0, 32'h0);
        tick();

        // Redirect with a fetch outstanding; reply two cycles later.
        step(0, 1, 0, 0, 0, 1, 32'h0000_3000);
        chk_val("kill_redirect", 64'(if_kill), 64'h0);
        tick();
        step(0, 1, 0, 0, 0, 0, 32'h0);
        chk_val("kill_on", 64'(if_kill), 64'h1);
        chk_val("kill_stall", 64'(stall_state), 64'b000001);
        tick();
        step(0, 1, 1, 0, 0, 0, 32'h0);
        chk_val("kill_rsp", 64'(if_kill), 64'h1);
        tick();
        step(0, 0, 0, 0, 0, 0, 32'h0);
        chk_val("kill_off", 64'(if_kill), 64'h0);
        chk_val("kill_off_stall", 64'(stall_state), 64'h0);
        tick();

        // Async reset while a redirect is pending drops it.
        step(0, 0, 0, 0, 1, 1, 32'h0000_4000);
        tick();
        drive(0, 0, 0, 0, 1, 1, 32'h0000_4000);
        #2;
        rst = 1'b0;
        #1;
        chk_val("rst_mid_stall", 64'(stall_state), 64'b001111);
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        #1;
        chk_val("rst_mid_idle", 64'(stall_state), 64'h0);
        chk_val("rst_mid_flag", 64'(b_flag_o), 64'h0);
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 0, 32'h0);
        chk_val("rst_pend_dropped", 64'(redirect_en), 64'h0);
        tick();

`ifdef PIPE_CTRL_PERF_EN
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 0, 0, 32'h0);
            tick();
        end
        step(0, 0, 0, 0, 0, 1, 32'h0000_5000);
        tick();
        step(0, 0, 0, 0, 0, 0, 32'h0);
        tick();
        step(0, 0, 0, 0, 0, 1, 32'h0000_6000);
        tick();
        step(0, 0, 0, 0, 0, 0, 32'h0);
        chk_val("perf_stall_cyc", 64'(perf_stall_cyc), 64'd5);
        chk_val("perf_flush_cnt", 64'(perf_flush_cnt), 64'd2);
        tick();
`endif

        // Random traffic.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            ifs  = ($urandom_range(0, 99) < 25);
            ids  = ($urandom_range(0, 99) < 20);
            mems = ($urandom_range(0, 99) < 25) && !m_kill;
            exb  = ($urandom_range(0, 99) < 20);
            busy = ($urandom_range(0, 99) < 50);
            rsp  = busy && ($urandom_range(0, 99) < 35);
            step(ifs, busy, rsp, ids, mems, exb, $urandom());
            tick();
        end
        step(0, 0, 0, 0, 0, 0, 32'h0);
`ifdef PIPE_CTRL_PERF_EN
        chk_val("rand_perf_stall", 64'(perf_stall_cyc), 64'(m_stall_cnt));
        chk_val("rand_perf_flush", 64'(perf_flush_cnt), 64'(m_flush_cnt));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
